ps2_letter_decoder: RTL and testbench
=====================================

# ps2_letter_decoder

Front end of the Hangman keyboard path. It receives PS/2 keyboard frames and decodes Set-2 scan codes into letter indices. It drives the `load`/`load_x` guess interface of the game handler with one-cycle pulses: letters A–Z map to 0–25 and Enter maps to 26, the start-game code. Break codes, unmapped keys and malformed frames never produce a `load`.

## Interface
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles allowed between consecutive PS/2 falling edges inside a frame before the frame is aborted.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  reset, asynchronous, active-high.
- `ps2_clk`  input  1  raw keyboard clock, asynchronous to `clk`.
- `ps2_dat`  input  1  raw keyboard data, asynchronous to `clk`.
- `load`  output  1  one-cycle pulse; a valid guess or start code is on `load_x`.
- `load_x`  output  5  decoded index: 0–25 = A–Z, 26 = Enter. Holds its value between pulses.
- `frame_err`  output  1  one-cycle pulse on a rejected frame.

## Operation
- **Input sync:** `ps2_clk` and `ps2_dat` each pass through a 2-flop synchronizer.
- **Edge detect:** a falling edge is the cycle where the previous synchronized `ps2_clk` is 1 and the current one is 0. Data is sampled in that same cycle.
- **Frame format:** 11 bits — start (0), 8 data bits LSB first, odd parity, stop (1).
- **Frame FSM:**
  - IDLE: on a falling edge, check the start bit. If it is 0, go to DATA; if it is 1, raise error.
  - DATA: take 8 edges.
  - PARITY: take 1 edge.
  - STOP: take 1 edge, then validate and return to IDLE.
- **Frame errors:**
  - Start bit = 1, parity of data+parity bit even, or stop bit = 0 → `frame_err` pulse and back to IDLE.
  - Any error also clears the prefix flags.
- **Timeout:** a counter, `$clog2(TIMEOUT_CYCLES+1)` bits wide, clears on every falling edge and counts while not in IDLE. When it reaches `TIMEOUT_CYCLES` → `frame_err` pulse and return to IDLE.
- **Prefix handling** (on each valid byte):
  - `E0` sets the ext flag.
  - `F0` sets the brk flag.
  - Any other byte is a code. It is decoded, then both flags clear.
- **Code decode:**
  - brk set → no output.
  - ext set → only `5A` (keypad Enter) maps to 26; all other extended codes are ignored.
  - Plain codes:
    - A–F: A=1C, B=32, C=21, D=23, E=24, F=2B
    - G–L: G=34, H=33, I=43, J=3B, K=42, L=4B
    - M–R: M=3A, N=31, O=44, P=4D, Q=15, R=2D
    - S–W: S=1B, T=2C, U=3C, V=2A, W=1D
    - X–Z and Enter: X=22, Y=35, Z=1A, Enter=5A→26
  - Unmapped codes → no output and no error.
- **Reset:** asynchronous assertion at any point, including mid-frame, forces the following state:
  - FSM to IDLE; bit counter, shift register, timeout counter and flags to 0.
  - Outputs: `load`=0, `load_x`=0, `frame_err`=0.
  - Repeat-filter last-code register (if compiled in) to 0.
- **Simultaneous events:** a timeout and a falling edge in the same cycle → the edge wins and the counter clears.

## Timing
- `load` and `frame_err` are registered and each asserts for exactly 1 cycle.
- `load_x` updates in the same cycle `load` rises and is stable until the next `load`.
- Latency: `load` rises exactly 1 cycle after the cycle in which the stop-bit falling edge is detected. That is 3 `clk` cycles after the stop-bit falling edge is first captured by synchronizer flop 1.
- `frame_err` follows the same 1-cycle rule after the offending edge or timeout.
- `load` and `frame_err` are never asserted together.
- Minimum spacing between `load` pulses is one PS/2 frame; no back-pressure, no buffering.

## Configuration
- `PS2_REPEAT_FILTER_EN` defined:
  - Typematic auto-repeat is suppressed. A make code equal to the last emitted make code is dropped unless its break (`F0` + same code) was received in between.
  - The last-code register is cleared by that break and by reset.
- Not defined: every mapped make code, including repeats, produces a `load` pulse.

## Test plan
- Frame `1C` (A) → one `load` pulse, `load_x`=0; the pulse rises 3 clk after the stop edge is captured.
- Frames `F0`,`1C` → no `load`. Then `1A` → `load`, `load_x`=25.
- `5A` → `load_x`=26. `E0`,`5A` → `load_x`=26. `E0`,`1C` → no `load`.
- Frame `1C` with a flipped parity bit → one `frame_err` pulse, no `load`. A clean `32` immediately after → `load_x`=1.
- Stall after 5 data bits for `TIMEOUT_CYCLES`+2 cycles → one `frame_err`. A next clean frame `24` → `load_x`=4.
- Repeat and reset:
  - `1C`,`1C`,`F0`,`1C`,`1C` with `PS2_REPEAT_FILTER_EN` → 2 `load` pulses; without it → 3 `load` pulses.
  - `reset` pulsed mid-frame → all outputs 0 and the next clean frame decodes correctly.

Source files
------------

// File: rtl/ps2_letter_decoder.sv
// ps2_letter_decoder: PS/2 Set-2 frame receiver that pulses load with letter index (A-Z=0..25, Enter=26).
// Optional typematic repeat suppression when PS2_REPEAT_FILTER_EN is defined.
module ps2_letter_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       load,
  output logic [4:0] load_x,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t          st;
  logic [1:0]      clk_s, dat_s;
  logic            clk_q, fall, dat_b;
  logic [2:0]      bitc;
  logic [7:0]      sh;
  logic            par, ext, brk;
  logic [TW-1:0]   to_cnt;
  logic [4:0]      idx;
  logic            timeout, bad_frame, is_code, hit, emit;
  function automatic logic [4:0] map_code(input logic [7:0] c);
    case (c)
      8'h1C: map_code = 5'd0;   8'h32: map_code = 5'd1;   8'h21: map_code = 5'd2;
      8'h23: map_code = 5'd3;   8'h24: map_code = 5'd4;   8'h2B: map_code = 5'd5;
      8'h34: map_code = 5'd6;   8'h33: map_code = 5'd7;   8'h43: map_code = 5'd8;
      8'h3B: map_code = 5'd9;   8'h42: map_code = 5'd10;  8'h4B: map_code = 5'd11;
      8'h3A: map_code = 5'd12;  8'h31: map_code = 5'd13;  8'h44: map_code = 5'd14;
      8'h4D: map_code = 5'd15;  8'h15: map_code = 5'd16;  8'h2D: map_code = 5'd17;
      8'h1B: map_code = 5'd18;  8'h2C: map_code = 5'd19;  8'h3C: map_code = 5'd20;
      8'h2A: map_code = 5'd21;  8'h1D: map_code = 5'd22;  8'h22: map_code = 5'd23;
      8'h35: map_code = 5'd24;  8'h1A: map_code = 5'd25;  8'h5A: map_code = 5'd26;
      default: map_code = 5'd31;
    endcase
  endfunction
  assign idx       = ext ? 5'd26 : map_code(sh);
  assign timeout   = st != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES);
  assign bad_frame = !dat_b || !(^{sh, par});
  assign is_code   = sh != 8'hE0 && sh != 8'hF0;
  assign hit       = is_code && !brk && (ext ? sh == 8'h5A : idx != 5'd31);
`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] last;
  assign emit = hit && {ext, sh} != last;
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= '0;
    else if (fall && st == STOP && !bad_frame && is_code)
      last <= emit ? {ext, sh} : (brk && {ext, sh} == last) ? 9'd0 : last;
`else
  assign emit = hit;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_q <= 1'b1;
      fall  <= 1'b0;
      dat_b <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_dat};
      clk_q <= clk_s[1];
      fall  <= clk_q && !clk_s[1];
      dat_b <= dat_s[1];
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st        <= IDLE;
      bitc      <= '0;
      sh        <= '0;
      par       <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      to_cnt    <= '0;
      load      <= 1'b0;
      load_x    <= '0;
      frame_err <= 1'b0;
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      to_cnt    <= (fall || st == IDLE) ? '0 : to_cnt + 1'b1;
      if (timeout) begin
        st        <= IDLE;
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end else if (fall) begin
        case (st)
          IDLE: begin
            if (dat_b) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end else begin
              st   <= DATA;
              bitc <= '0;
            end
          end
          DATA: begin
            sh   <= {dat_b, sh[7:1]};
            bitc <= bitc + 1'b1;
            if (bitc == 3'd7) st <= PARITY;
          end
          PARITY: begin
            par <= dat_b;
            st  <= STOP;
          end
          STOP: begin
            st <= IDLE;
            if (bad_frame) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end else if (sh == 8'hE0) ext <= 1'b1;
            else if (sh == 8'hF0) brk <= 1'b1;
            else begin
              ext <= 1'b0;
              brk <= 1'b0;
              if (emit) begin
                load   <= 1'b1;
                load_x <= idx;
              end
            end
          end
        endcase
      end
    end
endmodule

// File: tb/tb_ps2_letter_decoder.sv
// tb_ps2_letter_decoder: directed frames against ps2_letter_decoder with hand-computed expectations.
module tb_ps2_letter_decoder;
  localparam int TO = 200;
  logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic       load, frame_err;
  logic [4:0] load_x;
  int         total = 0, bad = 0, n_load = 0, n_err = 0, cyc = 0, stop_cyc = 0, load_cyc = 0;
  logic [4:0] last_x = '0;

  ps2_letter_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .load(load), .load_x(load_x), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (load) begin
      n_load++;
      last_x   = load_x;
      load_cyc = cyc;
    end
    if (frame_err) n_err++;
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_dat = b;
    repeat (4) @(negedge clk);
    ps2_clk  = 1'b0;
    stop_cyc = cyc;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic flip, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({load, load_x, frame_err} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000000", {load, load_x, frame_err});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_letter;
    int l0;
    l0 = n_load;
    send(8'h1C, 1'b0, 11);
    total++;
    if (n_load - l0 != 1) begin bad++; $display("FAIL letter_A_count got=%0d want=1", n_load - l0); end
    total++;
    if (last_x !== 5'd0) begin bad++; $display("FAIL letter_A_x got=%0d want=0", last_x); end
    total++;
    if (load_cyc - stop_cyc != 4) begin bad++; $display("FAIL latency got=%0d want=4", load_cyc - stop_cyc); end
  endtask

  task automatic test_break;
    int l0;
    l0 = n_load;
    send(8'hF0, 1'b0, 11);
    send(8'h1C, 1'b0, 11);
    total++;
    if (n_load != l0) begin bad++; $display("FAIL break_count got=%0d want=0", n_load - l0); end
    send(8'h1A, 1'b0, 11);
    total++;
    if (n_load - l0 != 1) begin bad++; $display("FAIL Z_count got=%0d want=1", n_load - l0); end
    total++;
    if (last_x !== 5'd25) begin bad++; $display("FAIL Z_x got=%0d want=25", last_x); end
  endtask

  task automatic test_enter;
    int l0;
    l0 = n_load;
    send(8'h5A, 1'b0, 11);
    total++;
    if (n_load - l0 != 1 || last_x !== 5'd26) begin
      bad++; $display("FAIL enter got=%0d/%0d want=1/26", n_load - l0, last_x);
    end
    l0 = n_load;
    send(8'h1C, 1'b0, 11);
    send(8'hE0, 1'b0, 11);
    send(8'h5A, 1'b0, 11);
    total++;
    if (n_load - l0 != 2 || last_x !== 5'd26) begin
      bad++; $display("FAIL kp_enter got=%0d/%0d want=2/26", n_load - l0, last_x);
    end
    l0 = n_load;
    send(8'hE0, 1'b0, 11);
    send(8'h1C, 1'b0, 11);
    total++;
    if (n_load != l0) begin bad++; $display("FAIL ext_1C got=%0d want=0", n_load - l0); end
  endtask

  task automatic test_parity;
    int l0, e0;
    l0 = n_load;
    e0 = n_err;
    send(8'h1C, 1'b1, 11);
    total++;
    if (n_err - e0 != 1 || n_load != l0) begin
      bad++; $display("FAIL parity err=%0d load=%0d want=1/0", n_err - e0, n_load - l0);
    end
    send(8'h32, 1'b0, 11);
    total++;
    if (n_load - l0 != 1 || last_x !== 5'd1) begin
      bad++; $display("FAIL after_parity got=%0d/%0d want=1/1", n_load - l0, last_x);
    end
  endtask

  task automatic test_timeout;
    int l0, e0;
    l0 = n_load;
    e0 = n_err;
    send(8'h24, 1'b0, 6);
    repeat (TO + 20) @(negedge clk);
    total++;
    if (n_err - e0 != 1 || n_load != l0) begin
      bad++; $display("FAIL timeout err=%0d load=%0d want=1/0", n_err - e0, n_load - l0);
    end
    send(8'h24, 1'b0, 11);
    total++;
    if (n_load - l0 != 1 || last_x !== 5'd4 || n_err - e0 != 1) begin
      bad++; $display("FAIL after_timeout got=%0d/%0d/%0d want=1/4/1", n_load - l0, last_x, n_err - e0);
    end
  endtask

  task automatic test_repeat;
    int l0, want;
`ifdef PS2_REPEAT_FILTER_EN
    want = 2;
`else
    want = 3;
`endif
    l0 = n_load;
    send(8'h1C, 1'b0, 11);
    send(8'h1C, 1'b0, 11);
    send(8'hF0, 1'b0, 11);
    send(8'h1C, 1'b0, 11);
    send(8'h1C, 1'b0, 11);
    total++;
    if (n_load - l0 != want) begin bad++; $display("FAIL repeat got=%0d want=%0d", n_load - l0, want); end
  endtask

  task automatic test_reset_mid;
    int l0, e0;
    send(8'h1A, 1'b0, 11);
    total++;
    if (last_x !== 5'd25) begin bad++; $display("FAIL pre_reset_x got=%0d want=25", last_x); end
    send(8'h2B, 1'b0, 4);
    @(negedge clk) reset = 1'b1;
    #1;
    total++;
    if ({load, load_x, frame_err} !== 7'd0) begin
      bad++; $display("FAIL mid_reset got=%b want=0000000", {load, load_x, frame_err});
    end
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    l0 = n_load;
    e0 = n_err;
    send(8'h2B, 1'b0, 11);
    total++;
    if (n_load - l0 != 1 || last_x !== 5'd5 || n_err != e0) begin
      bad++; $display("FAIL post_reset got=%0d/%0d/%0d want=1/5/0", n_load - l0, last_x, n_err - e0);
    end
  endtask

  initial begin
    test_reset;
    test_letter;
    test_break;
    test_enter;
    test_parity;
    test_timeout;
    test_repeat;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
